seg_disp: RTL and testbench

Display back-end for the temperature/light board. Consumes the 16-bit selected value and source flag from the data selector, converts it to four decimal digits with a sequential double-dabble engine, and drives a 4-digit multiplexed common-anode 7-segment display. Flag high formats the value as DS18B20 temperature (signed, 4 fractional bits); flag low formats it as an unsigned light reading.

---
 rtl/seg_disp.sv | 210 +++++++++++++++++++++
 tb/tb_seg_disp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp.sv
// 4-digit multiplexed 7-segment back-end: samples value/flag, converts via sequential double-dabble, scans digits.
// Optional build macro SEG_ZERO_BLANK_EN enables leading-zero blanking.
module seg_disp #(
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int SCAN_DIV       = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        flag,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    // state | meaning
    // IDLE  | waiting for refresh tick; inputs captured on tick
    // LOAD  | operand into shift register, BCD cleared
    // SHIFT | 16 add-3/shift steps
    // DONE  | BCD digits, mode and sign copied to display registers
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t             state, state_nxt;
    logic [REF_W-1:0]   ref_cnt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         dig_idx;
    logic               tick;

    logic [15:0]        mag;
    logic [3:0]         frac;
    logic [13:0]        temp_op, light_op, operand;
    logic               unused_mag_hi;

    logic [13:0]        op_q;
    logic               neg_q, mode_q;
    logic [15:0]        sh, bcd, bcd_adj;
    logic [3:0]         shift_cnt;

    logic [15:0]        disp_dig;
    logic               disp_mode, disp_neg, disp_valid;
    logic [3:0]         blank_mask;
    logic [3:0]         cur_dig;
    logic [7:0]         seg_nxt;
    logic [3:0]         an_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    assign tick = (ref_cnt == '0);

    // Temperature: integer part is limited to mag[10:4]; operand is in tenths of a degree.
    always_comb begin
        mag      = data_in[15] ? (~data_in + 16'd1) : data_in;
        frac     = 4'(({4'd0, mag[3:0]} * 8'd10) >> 4);
        temp_op  = {7'd0, mag[10:4]} * 14'd10 + {10'd0, frac};
        if (data_in[15] && (temp_op > 14'd999)) begin
            temp_op = 14'd999;
        end
        light_op = (data_in > 16'd9999) ? 14'd9999 : data_in[13:0];
        operand  = flag ? temp_op : light_op;
    end

    assign unused_mag_hi = ^mag[15:11];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            neg_q      <= 1'b0;
            mode_q     <= 1'b0;
            sh         <= '0;
            bcd        <= '0;
            shift_cnt  <= '0;
            disp_dig   <= '0;
            disp_mode  <= 1'b0;
            disp_neg   <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        op_q   <= operand;
                        neg_q  <= flag & data_in[15];
                        mode_q <= flag;
                    end
                end
                LOAD: begin
                    sh        <= {2'b00, op_q};
                    bcd       <= '0;
                    shift_cnt <= 4'd15;
                end
                SHIFT: begin
                    {bcd, sh} <= {bcd_adj[14:0], sh, 1'b0};
                    shift_cnt <= shift_cnt - 4'd1;
                end
                DONE: begin
                    disp_dig   <= bcd;
                    disp_mode  <= mode_q;
                    disp_neg   <= neg_q;
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    function automatic logic [7:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0:    digit_pat = 8'hC0;
            4'd1:    digit_pat = 8'hF9;
            4'd2:    digit_pat = 8'hA4;
            4'd3:    digit_pat = 8'hB0;
            4'd4:    digit_pat = 8'h99;
            4'd5:    digit_pat = 8'h92;
            4'd6:    digit_pat = 8'h82;
            4'd7:    digit_pat = 8'hF8;
            4'd8:    digit_pat = 8'h80;
            4'd9:    digit_pat = 8'h90;
            default: digit_pat = 8'hFF;
        endcase
    endfunction

`ifdef SEG_ZERO_BLANK_EN
    logic lz3, lz2, lz1;
    assign lz3 = (disp_dig[15:12] == 4'd0);
    assign lz2 = lz3 && (disp_dig[11:8] == 4'd0);
    assign lz1 = lz2 && (disp_dig[7:4] == 4'd0);
    // Temperature only ever blanks the tens digit; d3 is the sign position.
    assign blank_mask = disp_mode ? {1'b0, (disp_dig[11:8] == 4'd0), 2'b00}
                                  : {lz3, lz2, lz1, 1'b0};
`else
    assign blank_mask = 4'b0000;
`endif

    always_comb begin
        cur_dig = disp_dig[{dig_idx, 2'b00} +: 4];
        seg_nxt = digit_pat(cur_dig);
        an_nxt  = ~(4'b0001 << dig_idx);
        if (!disp_valid || blank_mask[dig_idx]) begin
            seg_nxt = 8'hFF;
        end else if (disp_mode) begin
            if (dig_idx == 2'd3) begin
                seg_nxt = disp_neg ? 8'hBF : 8'hFF;
            end else if (dig_idx == 2'd1) begin
                seg_nxt = seg_nxt & 8'h7F;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= 4'hF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_disp.sv
// Self-checking bench for seg_disp: fixed vector table, random vectors against a decimal model, and timing sequences.
module tb_seg_disp;

    localparam int R = 64;
    localparam int S = 4;
    localparam logic [7:0] PAT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        flag = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seg_disp #(.REFRESH_CYCLES(R), .SCAN_DIV(S)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .flag(flag), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] data;
        logic        flag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: decimal arithmetic on the documented formatting rules.
    function automatic logic [31:0] model(input logic [15:0] d, input logic f);
        int dv, v, mag, digs[4];
        bit neg;
        logic [7:0] p[4];
        dv  = int'(d);
        neg = 0;
        if (!f) begin
            v = (dv > 9999) ? 9999 : dv;
        end else begin
            neg = d[15];
            mag = neg ? (65536 - dv) : dv;
            v   = ((mag / 16) % 128) * 10 + ((mag % 16) * 10) / 16;
            if (neg && v > 999) v = 999;
        end
        digs[0] = v % 10;
        digs[1] = (v / 10) % 10;
        digs[2] = (v / 100) % 10;
        digs[3] = (v / 1000) % 10;
        for (int i = 0; i < 4; i++) p[i] = PAT[digs[i]];
        if (f) begin
            p[3] = neg ? 8'hBF : 8'hFF;
            p[1] = p[1] & 8'h7F;
`ifdef SEG_ZERO_BLANK_EN
            if (digs[2] == 0) p[2] = 8'hFF;
`endif
        end else begin
`ifdef SEG_ZERO_BLANK_EN
            if (digs[3] == 0) p[3] = 8'hFF;
            if (digs[3] == 0 && digs[2] == 0) p[2] = 8'hFF;
            if (digs[3] == 0 && digs[2] == 0 && digs[1] == 0) p[1] = 8'hFF;
`endif
        end
        return {p[3], p[2], p[1], p[0]};
    endfunction

    // Collect the pattern shown on each anode over two full scan rounds.
    task automatic read_disp(output logic [31:0] got, output int bad_an);
        got    = 'x;
        bad_an = 0;
        for (int i = 0; i < 8 * S; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: got[7:0]   = seg;
                4'b1101: got[15:8]  = seg;
                4'b1011: got[23:16] = seg;
                4'b0111: got[31:24] = seg;
                default: bad_an++;
            endcase
        end
    endtask

    task automatic check_blank(input string name);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (seg !== 8'hFF) bad++;
            if ($countones(~an) != 1) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic wait_tick();
        int found = 0;
        for (int i = 0; i < 2 * R && found == 0; i++) begin
            @(negedge clk);
            if (cyc % R == 0) found = 1;
        end
        check("tick_wait", found, 1);
        @(posedge clk);
    endtask

    task automatic apply_and_check(input string name, input logic [15:0] d, input logic f,
                                   input logic [31:0] exp);
        logic [31:0] got;
        int bad_an;
        @(negedge clk);
        data_in = d;
        flag    = f;
        repeat (R + 20) @(negedge clk);
        read_disp(got, bad_an);
        check(name, got, exp);
        check({name, "_an"}, bad_an, 0);
    endtask

    initial begin
        logic [31:0] got;
        int bad_an;
        logic [15:0] rd;
        logic rf;

        vecs.push_back('{16'd1234,  1'b0, 32'hF9A4B099});
        vecs.push_back('{16'd12345, 1'b0, 32'h90909090});
        vecs.push_back('{16'd9999,  1'b0, 32'h90909090});
        vecs.push_back('{16'h0191,  1'b1, 32'hFFA412C0});
        vecs.push_back('{16'hFF5E,  1'b1, 32'hBFF940F9});
        vecs.push_back('{16'hF9C0,  1'b1, 32'hBF901090});
        vecs.push_back('{16'h07F0,  1'b1, 32'hFFA478C0});
`ifdef SEG_ZERO_BLANK_EN
        vecs.push_back('{16'd7,     1'b0, 32'hFFFFFFF8});
        vecs.push_back('{16'd0,     1'b0, 32'hFFFFFFC0});
        vecs.push_back('{16'h0000,  1'b1, 32'hFFFF40C0});
`else
        vecs.push_back('{16'd7,     1'b0, 32'hC0C0C0F8});
        vecs.push_back('{16'd0,     1'b0, 32'hC0C0C0C0});
        vecs.push_back('{16'h0000,  1'b1, 32'hFFC040C0});
`endif

        repeat (3) @(negedge clk);
        check("reset_outputs", {seg, an}, 12'hFFF);
        rst = 1'b0;
        check_blank("blank_before_done");

        foreach (vecs[i]) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].flag, vecs[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            rd = 16'($urandom);
            rf = 1'($urandom_range(0, 1));
            apply_and_check($sformatf("rand%0d_%h_%0d", i, rd, rf), rd, rf, model(rd, rf));
        end

        // Input changed during a conversion must wait for the next tick.
        @(negedge clk);
        data_in = 16'd1234;
        flag    = 1'b0;
        wait_tick();
        repeat (5) @(negedge clk);
        data_in = 16'd4321;
        repeat (20) @(negedge clk);
        read_disp(got, bad_an);
        check("hold_old_value", got, 32'hF9A4B099);
        repeat (40) @(negedge clk);
        read_disp(got, bad_an);
        check("new_after_tick", got, 32'h99B0A4F9);

        // Reset during SHIFT blanks outputs and the post-reset tick restarts conversion.
        data_in = 16'h0191;
        flag    = 1'b1;
        wait_tick();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_shift", {seg, an}, 12'hFFF);
        rst = 1'b0;
        check_blank("blank_after_reset");
        repeat (10) @(negedge clk);
        read_disp(got, bad_an);
        check("restart_after_reset", got, 32'hFFA412C0);
        check("restart_an", bad_an, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
